// File: rtl/snitch_icache_refill_arbiter.sv
// Round-robin arbiter sharing the single L1 refill port among NR_PORTS L0 requesters.
// Request IDs carry the port index so that L1 responses are routed back combinationally.
module snitch_icache_refill_arbiter #(
  parameter int unsigned NR_PORTS     = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned IN_ID_WIDTH  = 1,
  parameter int unsigned MAX_PENDING  = 4,
  localparam int unsigned PW           = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
  localparam int unsigned OUT_ID_WIDTH = IN_ID_WIDTH + PW,
  localparam int unsigned CW           = $clog2(MAX_PENDING + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_valid_i,
  output logic                            flush_ready_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0]  in_addr_i,
  input  logic [NR_PORTS*IN_ID_WIDTH-1:0] in_id_i,
  input  logic [NR_PORTS-1:0]             in_valid_i,
  output logic [NR_PORTS-1:0]             in_ready_o,
  output logic [DATA_WIDTH-1:0]           in_rsp_data_o,
  output logic [IN_ID_WIDTH-1:0]          in_rsp_id_o,
  output logic [NR_PORTS-1:0]             in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]             in_rsp_ready_i,
  output logic [ADDR_WIDTH-1:0]           out_addr_o,
  output logic [OUT_ID_WIDTH-1:0]         out_id_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  input  logic [DATA_WIDTH-1:0]           out_rsp_data_i,
  input  logic [OUT_ID_WIDTH-1:0]         out_rsp_id_i,
  input  logic                            out_rsp_valid_i,
  output logic                            out_rsp_ready_o
);

  typedef enum logic [1:0] {ARB = 2'd0, DRAIN = 2'd1, ACK = 2'd2} state_e;

  state_e                  state_q;
  logic [PW-1:0]           rr_ptr_q;
  logic [CW-1:0]           pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q;
  logic [OUT_ID_WIDTH-1:0] out_id_q;
  logic                    out_valid_q;
  logic                    flush_ready_q;

  logic                    gnt_found, cand_hit, may_load, load;
  logic [PW-1:0]           gnt_idx, cand_idx, rr_next, rsp_idx;
  logic [ADDR_WIDTH-1:0]   gnt_addr;
  logic [IN_ID_WIDTH-1:0]  gnt_id;
  logic [CW:0]             occupancy;
  logic                    req_hs, rsp_valid, rsp_hs, rsp_idx_ok;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    cand_hit  = 1'b0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      cand_idx  = PW'((32'(rr_ptr_q) + i) % NR_PORTS);
      cand_hit  = !gnt_found && in_valid_i[cand_idx];
      gnt_idx   = cand_hit ? cand_idx : gnt_idx;
      gnt_found = gnt_found | cand_hit;
    end
  end

  always_comb begin
    gnt_addr = '0;
    gnt_id   = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      gnt_addr = (32'(gnt_idx) == i) ? in_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] : gnt_addr;
      gnt_id   = (32'(gnt_idx) == i) ? in_id_i[i*IN_ID_WIDTH +: IN_ID_WIDTH] : gnt_id;
    end
  end

  // The stage entry counts against the budget so a stalled request cannot overshoot it.
  assign occupancy  = {1'b0, pending_q} + (CW+1)'(out_valid_q);
  assign may_load   = !rst_i && (state_q == ARB) && (occupancy < (CW+1)'(MAX_PENDING))
                      && (!out_valid_q || out_ready_i);
  assign load       = may_load && gnt_found;
  assign in_ready_o = load ? (NR_PORTS'(1'b1) << gnt_idx) : '0;
  assign rr_next    = (32'(gnt_idx) == NR_PORTS - 1) ? '0 : gnt_idx + PW'(1);

  assign req_hs      = out_valid_q && out_ready_i;
  assign out_addr_o  = out_addr_q;
  assign out_id_o    = out_id_q;
  assign out_valid_o = out_valid_q;
  assign flush_ready_o = flush_ready_q;

  assign rsp_idx         = out_rsp_id_i[OUT_ID_WIDTH-1 -: PW];
  assign rsp_idx_ok      = 32'(rsp_idx) < NR_PORTS;
  assign rsp_valid       = out_rsp_valid_i && !rst_i;
  assign in_rsp_valid_o  = rsp_valid ? (NR_PORTS'(1'b1) << rsp_idx) : '0;
  assign out_rsp_ready_o = !rst_i && rsp_idx_ok && in_rsp_ready_i[rsp_idx];
  assign in_rsp_id_o     = out_rsp_id_i[IN_ID_WIDTH-1:0];
  assign in_rsp_data_o   = out_rsp_data_i;
  assign rsp_hs          = rsp_valid && out_rsp_ready_o;

  // Outstanding-request count: L1 acceptances minus delivered responses.
  always_comb begin
    pending_d = pending_q;
    case ({req_hs, rsp_hs})
      2'b10:   pending_d = pending_q + CW'(1);
      2'b01:   pending_d = (pending_q != '0) ? pending_q - CW'(1) : pending_q;
      default: pending_d = pending_q;
    endcase
  end

  // Output stage, round-robin pointer and flush sequencing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      pending_q     <= '0;
      out_addr_q    <= '0;
      out_id_q      <= '0;
      out_valid_q   <= 1'b0;
      flush_ready_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        out_addr_q  <= gnt_addr;
        out_id_q    <= {gnt_idx, gnt_id};
        out_valid_q <= 1'b1;
        rr_ptr_q    <= rr_next;
      end else if (req_hs) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ARB: begin
          flush_ready_q <= 1'b0;
          if (flush_valid_i) state_q <= DRAIN;
        end
        DRAIN: begin
          // Look at next-cycle occupancy so the ack follows the last response by one cycle.
          if ((!out_valid_q || out_ready_i) && (pending_d == '0)) begin
            state_q       <= ACK;
            flush_ready_q <= 1'b1;
          end
        end
        ACK: begin
          state_q       <= ARB;
          flush_ready_q <= 1'b0;
          rr_ptr_q      <= '0;
        end
        default: begin
          state_q       <= ARB;
          flush_ready_q <= 1'b0;
        end
      endcase
    end
  end

  rsp_pending_a: assert property (@(posedge clk_i) disable iff (rst_i)
    out_rsp_valid_i |-> (pending_q != '0));
  rsp_idx_a: assert property (@(posedge clk_i) disable iff (rst_i)
    out_rsp_valid_i |-> rsp_idx_ok);

endmodule

// File: tb/tb_snitch_icache_refill_arbiter.sv
// Scoreboard bench for snitch_icache_refill_arbiter: random and directed traffic
// checked against a transaction-level reference of arbitration, budget and flush rules.
module tb_snitch_icache_refill_arbiter;
  localparam int NP = 4, AW = 32, DW = 128, IW = 1, MP = 4, PW = 2, OW = IW + PW;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_valid_i, flush_ready_o;
  logic [NP*AW-1:0]  in_addr_i;
  logic [NP*IW-1:0]  in_id_i;
  logic [NP-1:0]     in_valid_i, in_ready_o;
  logic [DW-1:0]     in_rsp_data_o;
  logic [IW-1:0]     in_rsp_id_o;
  logic [NP-1:0]     in_rsp_valid_o, in_rsp_ready_i;
  logic [AW-1:0]     out_addr_o;
  logic [OW-1:0]     out_id_o;
  logic              out_valid_o, out_ready_i;
  logic [DW-1:0]     out_rsp_data_i;
  logic [OW-1:0]     out_rsp_id_i;
  logic              out_rsp_valid_i, out_rsp_ready_o;

  always #5 clk = ~clk;

  snitch_icache_refill_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .in_addr_i(in_addr_i), .in_id_i(in_id_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rsp_data_o(in_rsp_data_o), .in_rsp_id_o(in_rsp_id_o),
    .in_rsp_valid_o(in_rsp_valid_o), .in_rsp_ready_i(in_rsp_ready_i),
    .out_addr_o(out_addr_o), .out_id_o(out_id_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rsp_data_i(out_rsp_data_i), .out_rsp_id_i(out_rsp_id_i),
    .out_rsp_valid_i(out_rsp_valid_i), .out_rsp_ready_o(out_rsp_ready_o)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [OW-1:0] id; } req_t;
  typedef struct packed { logic [NP-1:0] vld; logic [IW-1:0] id; logic [DW-1:0] data; logic rdy; } rsp_t;

  req_t          req_exp_q[$];   // expected L1 requests, in order
  rsp_t          rsp_exp_q[$];   // expected routed responses
  req_t          stage_m[$];     // reference: accepted but not yet taken by L1
  logic [OW-1:0] pend_ids[$];    // reference: taken by L1, awaiting response
  int            rr, phase;      // phase 0 = arbitrating, 1 = draining, 2 = acking
  int            checks = 0, failures = 0, hs_count = 0;
  logic          force_id1 = 1'b0, rrdy_force = 1'b0;
  logic [NP-1:0] rrdy_mask = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    stage_m.delete(); pend_ids.delete(); req_exp_q.delete(); rsp_exp_q.delete();
    rr = 0; phase = 0;
  endtask

  // Asynchronous reset with ports still requesting: outputs must drop at once.
  task automatic reset_mid();
    @(negedge clk);
    in_valid_i = '1; out_ready_i = 1'b0; out_rsp_valid_i = 1'b0; flush_valid_i = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_in_ready", in_ready_o, '0);
    chk("rst_flush_ready", flush_ready_o, 1'b0);
    chk("rst_rsp_valid", in_rsp_valid_o, '0);
    clear_model();
    @(negedge clk);
    in_valid_i = '0; rst = 1'b0;
  endtask

  task automatic step(input logic [NP-1:0] vmask, input int ordy_pct, input int rsp_pct, input logic flush);
    logic [NP-1:0] exp_rdy;
    logic [OW-1:0] rid;
    req_t nr, tk;
    rsp_t r;
    int g, k;
    bit found, may_load, rsp_hs;
    @(negedge clk);
    in_valid_i = vmask;
    for (int p = 0; p < NP; p++) begin
      in_addr_i[p*AW +: AW] = $urandom;
      in_id_i[p*IW +: IW]   = force_id1 ? '1 : IW'($urandom);
    end
    out_ready_i     = ($urandom_range(0, 99) < ordy_pct);
    flush_valid_i   = flush;
    in_rsp_ready_i  = rrdy_force ? rrdy_mask : NP'($urandom);
    out_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
    out_rsp_id_i    = OW'($urandom);
    out_rsp_valid_i = 1'b0;
    rsp_hs = 0; k = 0;
    if (pend_ids.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
      k = $urandom_range(0, pend_ids.size() - 1);
      rid = pend_ids[k];
      out_rsp_valid_i = 1'b1;
      out_rsp_id_i    = rid;
      rsp_hs = in_rsp_ready_i[rid[OW-1 -: PW]];
      r.vld = NP'(1) << rid[OW-1 -: PW];
      r.id = rid[IW-1:0]; r.data = out_rsp_data_i; r.rdy = rsp_hs;
      rsp_exp_q.push_back(r);
    end
    #1;
    may_load = (phase == 0) && (pend_ids.size() + stage_m.size() < MP)
               && (stage_m.size() == 0 || out_ready_i);
    found = 0; g = 0;
    for (int j = 0; j < NP; j++)
      if (!found && vmask[(rr + j) % NP]) begin found = 1; g = (rr + j) % NP; end
    exp_rdy = (may_load && found) ? NP'(1) << g : '0;
    chk("in_ready", in_ready_o, exp_rdy);
    chk("out_valid", out_valid_o, stage_m.size() != 0);
    chk("flush_ready", flush_ready_o, phase == 2);
    if (rsp_hs) pend_ids.delete(k);
    if (stage_m.size() != 0 && out_ready_i) begin
      tk = stage_m.pop_front();
      pend_ids.push_back(tk.id);
    end
    if (may_load && found) begin
      nr.addr = in_addr_i[g*AW +: AW];
      nr.id   = {PW'(g), in_id_i[g*IW +: IW]};
      stage_m.push_back(nr);
      req_exp_q.push_back(nr);
      rr = (g + 1) % NP;
    end
    case (phase)
      0: if (flush) phase = 1;
      1: if (stage_m.size() == 0 && pend_ids.size() == 0) phase = 2;
      2: begin phase = 0; rr = 0; end
      default: phase = 0;
    endcase
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or a response.
  req_t          mon_req;
  rsp_t          mon_rsp;
  logic          stall_seen = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [OW-1:0] hold_id;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (out_valid_o && out_ready_i) begin
        hs_count++;
        if (req_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL req_extra actual=%0h required=none", out_id_o);
        end else begin
          mon_req = req_exp_q.pop_front();
          chk("out_addr", out_addr_o, mon_req.addr);
          chk("out_id", out_id_o, mon_req.id);
        end
      end
      if (out_rsp_valid_i || (in_rsp_valid_o != '0)) begin
        if (rsp_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_extra actual=%0h required=none", in_rsp_valid_o);
        end else begin
          mon_rsp = rsp_exp_q.pop_front();
          chk("rsp_valid", in_rsp_valid_o, mon_rsp.vld);
          chk("rsp_id", in_rsp_id_o, mon_rsp.id);
          chk("rsp_data", in_rsp_data_o, mon_rsp.data);
          chk("rsp_ready", out_rsp_ready_o, mon_rsp.rdy);
        end
      end
      if (stall_seen && out_valid_o) begin
        chk("hold_addr", out_addr_o, hold_addr);
        chk("hold_id", out_id_o, hold_id);
      end
      stall_seen = out_valid_o && !out_ready_i;
      hold_addr  = out_addr_o;
      hold_id    = out_id_o;
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    in_valid_i = '1; in_addr_i = '0; in_id_i = '0; out_ready_i = 1'b0; flush_valid_i = 1'b0;
    in_rsp_ready_i = '0; out_rsp_data_i = '0; out_rsp_id_i = '0; out_rsp_valid_i = 1'b0;
    clear_model();
    #7;
    chk("reset_out_valid", out_valid_o, 1'b0);
    chk("reset_in_ready", in_ready_o, '0);
    chk("reset_flush_ready", flush_ready_o, 1'b0);
    @(negedge clk);
    in_valid_i = '0; rst = 1'b0;

    // Ports 0 and 2 continuously requesting, immediate responses.
    rrdy_force = 1'b1; rrdy_mask = '1;
    for (int n = 0; n < 12; n++) step(4'b0101, 100, 100, 1'b0);

    // Budget: no responses, everyone requesting -> exactly MAX_PENDING handshakes.
    reset_mid();
    base = hs_count;
    for (int n = 0; n < 10; n++) step(4'b1111, 100, 0, 1'b0);
    #2;
    chk("budget_handshakes", hs_count - base, MP);
    step(4'b1111, 100, 100, 1'b0);
    step(4'b1111, 100, 0, 1'b0);
    chk("budget_resume", in_ready_o != '0, 1'b1);

    // L1 stall with port 1 holding the stage.
    reset_mid();
    step(4'b0010, 100, 0, 1'b0);
    for (int n = 0; n < 5; n++) step(4'b1111, 0, 0, 1'b0);

    // Flush with two requests outstanding; pointer left at port 2 beforehand.
    reset_mid();
    step(4'b0010, 100, 0, 1'b0);
    step(4'b0010, 100, 0, 1'b0);
    step(4'b0000, 100, 0, 1'b0);
    step(4'b0000, 100, 0, 1'b1);
    for (int n = 0; n < 2; n++) step(4'b1111, 100, 0, 1'b0);
    for (int n = 0; n < 2; n++) step(4'b1111, 100, 100, 1'b0);
    for (int n = 0; n < 3; n++) step(4'b1111, 100, 0, 1'b0);

    // Response routing for id {3,1} with only port 3 ready.
    reset_mid();
    force_id1 = 1'b1;
    step(4'b1000, 100, 0, 1'b0);
    step(4'b0000, 100, 0, 1'b0);
    force_id1 = 1'b0; rrdy_mask = 4'b1000;
    step(4'b0000, 100, 100, 1'b0);
    chk("route_valid", in_rsp_valid_o, 4'b1000);
    chk("route_id", in_rsp_id_o, 1'b1);
    chk("route_ready", out_rsp_ready_o, 1'b1);
    rrdy_force = 1'b0;

    // Random traffic with occasional flushes and one reset mid-burst.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) reset_mid();
      step(NP'($urandom), 70, 50, ($urandom_range(0, 49) == 0));
    end

    // Drain everything so every expectation must have been presented.
    rrdy_force = 1'b1; rrdy_mask = '1;
    for (int n = 0; n < 30; n++) step(4'b0000, 100, 100, 1'b0);
    #2;
    chk("req_queue_empty", req_exp_q.size(), 0);
    chk("rsp_queue_empty", rsp_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
